// File: rtl/ccc_pll_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// ccc_seq_pkg
// Shared types and constants for the CCC/PLL power-up sequencer.
//   - seq_state_e : sequencer FSM states (VSETUP/VACCESS only reachable when
//                   CCC_SEQ_VERIFY_EN is defined)
//   - CCC_ADDR_W  : width of a CCC dynamic-configuration register address
//   - CCC_DATA_W  : width of a CCC dynamic-configuration register value
// -----------------------------------------------------------------------------
package ccc_seq_pkg;

  localparam int CCC_ADDR_W = 6;
  localparam int CCC_DATA_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    PWRDN,
    SETUP,
    ACCESS,
    VSETUP,
    VACCESS,
    RELEASE,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } seq_state_e;

  // True while an APB transfer (write or read-back) owns the bus.
  function automatic logic is_apb_state(input seq_state_e st);
    return (st == SETUP) || (st == ACCESS) || (st == VSETUP) || (st == VACCESS);
  endfunction

endpackage

// File: rtl/ccc_pll_sequencer_lock_sync.sv
// -----------------------------------------------------------------------------
// ccc_lock_sync
// Two-flop synchroniser bringing the asynchronous PLL LOCK into the
// sequencer clock domain. Both stages reset to 0 so a freshly reset
// sequencer never sees a stale lock.
// Ports:
//   clk      in  sequencer clock
//   rst_n    in  asynchronous active-low reset
//   async_in in  asynchronous input (CCC LOCK)
//   sync_out out synchronised copy, 2 cycles of latency
// -----------------------------------------------------------------------------
module ccc_lock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/ccc_pll_sequencer.sv
// -----------------------------------------------------------------------------
// ccc_pll_sequencer
// Power-up / dynamic-configuration sequencer for the fabric CCC/PLL.
// Holds the PLL in power-down and reset, writes a table of configuration
// registers over the CCC APB port, releases the PLL, qualifies LOCK and then
// releases the GL0 fabric reset. Lock loss in RUN re-qualifies without
// reconfiguring; failing to qualify within LOCK_TIMEOUT cycles lands in FAIL.
//
// Optional feature: define CCC_SEQ_VERIFY_EN to read back every written
// register (VSETUP/VACCESS); a read-back mismatch goes straight to FAIL
// and the PLL is never released. Without it PRDATA is ignored.
//
// Ports:
//   CLK, RESET_N                 sequencer clock, async active-low reset
//   START                        one-cycle request for a full sequence
//   CFG_ADDR, CFG_DATA           flattened register table, entry 0 in LSBs
//   PRESET_N..PWDATA, PRDATA     CCC APB port (no PREADY: 2-cycle transfers)
//   PLL_ARST_N, PLL_POWERDOWN_N  PLL controls
//   LOCK                         CCC LOCK, asynchronous to CLK
//   BUSY, READY, ERROR           status
//   FAB_RESET_N                  active-low reset for GL0 logic
// All outputs are registered and reset to 0.
// -----------------------------------------------------------------------------
module ccc_pll_sequencer
  import ccc_seq_pkg::*;
#(
  parameter int NUM_REGS     = 4,
  parameter int ARST_CYCLES  = 16,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                           CLK,
  input  logic                           RESET_N,
  input  logic                           START,
  input  logic [CCC_ADDR_W*NUM_REGS-1:0] CFG_ADDR,
  input  logic [CCC_DATA_W*NUM_REGS-1:0] CFG_DATA,
  output logic                           PRESET_N,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [CCC_ADDR_W-1:0]          PADDR,
  output logic [CCC_DATA_W-1:0]          PWDATA,
  input  logic [CCC_DATA_W-1:0]          PRDATA,
  output logic                           PLL_ARST_N,
  output logic                           PLL_POWERDOWN_N,
  input  logic                           LOCK,
  output logic                           BUSY,
  output logic                           READY,
  output logic                           ERROR,
  output logic                           FAB_RESET_N
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int DLY_W = $clog2(ARST_CYCLES);
  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(ARST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_DONE = STB_W'(LOCK_STABLE);
  localparam logic [TMO_W-1:0] TMO_DONE = TMO_W'(LOCK_TIMEOUT);

  // ---------------------------------------------------------------------------
  // Unflattened configuration table
  // ---------------------------------------------------------------------------
  logic [CCC_ADDR_W-1:0] addr_tbl [NUM_REGS];
  logic [CCC_DATA_W-1:0] data_tbl [NUM_REGS];

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_tbl
    assign addr_tbl[gi] = CFG_ADDR[gi*CCC_ADDR_W +: CCC_ADDR_W];
    assign data_tbl[gi] = CFG_DATA[gi*CCC_DATA_W +: CCC_DATA_W];
  end

  // ---------------------------------------------------------------------------
  // LOCK synchroniser
  // ---------------------------------------------------------------------------
  logic lock_s;

  ccc_lock_sync u_lock_sync (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .async_in (LOCK),
    .sync_out (lock_s)
  );

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DLY_W-1:0] dly_q, dly_d;   // shared by PWRDN and RELEASE holds
  logic [STB_W-1:0] stb_q, stb_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [STB_W-1:0] stb_inc;
  logic [TMO_W-1:0] tmo_inc;

  assign stb_inc = stb_q + 1'b1;
  assign tmo_inc = tmo_q + 1'b1;

  // Registered outputs
  logic                  preset_n_q, preset_n_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [CCC_ADDR_W-1:0] paddr_q, paddr_d;
  logic [CCC_DATA_W-1:0] pwdata_q, pwdata_d;
  logic                  pll_arst_n_q, pll_arst_n_d;
  logic                  pll_pd_n_q, pll_pd_n_d;
  logic                  busy_q, busy_d;
  logic                  ready_q, ready_d;
  logic                  error_q, error_d;
  logic                  fab_reset_n_q, fab_reset_n_d;

`ifndef CCC_SEQ_VERIFY_EN
  logic unused_prdata;
  assign unused_prdata = ^PRDATA;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    stb_d   = stb_q;
    tmo_d   = tmo_q;

    case (state_q)
      IDLE, FAIL: begin
        if (START) begin
          state_d = PWRDN;
          dly_d   = '0;
        end
      end

      PWRDN: begin
        if (dly_q == DLY_LAST) begin
          state_d = SETUP;
          idx_d   = '0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      SETUP: state_d = ACCESS;

`ifdef CCC_SEQ_VERIFY_EN
      ACCESS:  state_d = VSETUP;
      VSETUP:  state_d = VACCESS;
      // PRDATA is taken on the edge that closes the read-back transfer;
      // PWDATA still holds the value just written to this address.
      VACCESS: begin
        if (PRDATA != pwdata_q) begin
          state_d = FAIL;
        end else if (idx_q == LAST_IDX) begin
          state_d = RELEASE;
          dly_d   = '0;
        end else begin
          state_d = SETUP;
          idx_d   = idx_q + 1'b1;
        end
      end
`else
      ACCESS: begin
        if (idx_q == LAST_IDX) begin
          state_d = RELEASE;
          dly_d   = '0;
        end else begin
          state_d = SETUP;
          idx_d   = idx_q + 1'b1;
        end
      end
`endif

      RELEASE: begin
        if (dly_q == DLY_LAST) begin
          state_d = WAIT_LOCK;
          tmo_d   = '0;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      // The timeout budget spans both lock states; a drop back from STABLE
      // keeps the budget already consumed.
      WAIT_LOCK: begin
        tmo_d = tmo_inc;
        if (tmo_inc == TMO_DONE) begin
          state_d = FAIL;
        end else if (lock_s) begin
          state_d = STABLE;
          stb_d   = '0;
        end
      end

      STABLE: begin
        tmo_d = tmo_inc;
        if (tmo_inc == TMO_DONE) begin
          state_d = FAIL;
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (stb_inc == STB_DONE) begin
          state_d = RUN;
        end else begin
          stb_d = stb_inc;
        end
      end

      RUN: begin
        if (START) begin
          state_d = PWRDN;
          dly_d   = '0;
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
          tmo_d   = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state, so every output is a flop that
  // changes on the same edge as the state it belongs to.
  // ---------------------------------------------------------------------------
  always_comb begin
    preset_n_d    = 1'b1;
    psel_d        = is_apb_state(state_d);
    penable_d     = 1'b0;
    pwrite_d      = 1'b0;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pll_arst_n_d  = 1'b0;
    pll_pd_n_d    = 1'b0;
    busy_d        = 1'b1;
    ready_d       = 1'b0;
    error_d       = 1'b0;
    fab_reset_n_d = 1'b0;

    case (state_d)
      IDLE: begin
        preset_n_d = 1'b0;
        busy_d     = 1'b0;
      end
      SETUP: begin
        pwrite_d = 1'b1;
        paddr_d  = addr_tbl[idx_d];
        pwdata_d = data_tbl[idx_d];
      end
      ACCESS: begin
        pwrite_d  = 1'b1;
        penable_d = 1'b1;
      end
      VACCESS: penable_d = 1'b1;
      RELEASE: pll_pd_n_d = 1'b1;
      WAIT_LOCK, STABLE: begin
        pll_pd_n_d   = 1'b1;
        pll_arst_n_d = 1'b1;
      end
      RUN: begin
        pll_pd_n_d    = 1'b1;
        pll_arst_n_d  = 1'b1;
        ready_d       = 1'b1;
        fab_reset_n_d = 1'b1;
        busy_d        = 1'b0;
      end
      FAIL: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      dly_q         <= '0;
      stb_q         <= '0;
      tmo_q         <= '0;
      preset_n_q    <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pll_arst_n_q  <= 1'b0;
      pll_pd_n_q    <= 1'b0;
      busy_q        <= 1'b0;
      ready_q       <= 1'b0;
      error_q       <= 1'b0;
      fab_reset_n_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dly_q         <= dly_d;
      stb_q         <= stb_d;
      tmo_q         <= tmo_d;
      preset_n_q    <= preset_n_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pll_arst_n_q  <= pll_arst_n_d;
      pll_pd_n_q    <= pll_pd_n_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      error_q       <= error_d;
      fab_reset_n_q <= fab_reset_n_d;
    end
  end

  assign PRESET_N        = preset_n_q;
  assign PSEL            = psel_q;
  assign PENABLE         = penable_q;
  assign PWRITE          = pwrite_q;
  assign PADDR           = paddr_q;
  assign PWDATA          = pwdata_q;
  assign PLL_ARST_N      = pll_arst_n_q;
  assign PLL_POWERDOWN_N = pll_pd_n_q;
  assign BUSY            = busy_q;
  assign READY           = ready_q;
  assign ERROR           = error_q;
  assign FAB_RESET_N     = fab_reset_n_q;

endmodule

// File: tb/tb_ccc_pll_sequencer.sv
// -----------------------------------------------------------------------------
// tb_ccc_pll_sequencer
// Directed bench for ccc_pll_sequencer with NUM_REGS=2, ARST_CYCLES=4,
// LOCK_STABLE=8, LOCK_TIMEOUT=100. Inputs change 1 ns after the rising edge
// and outputs are sampled at the same point. With CCC_SEQ_VERIFY_EN defined
// the read-back failure scenario is added.
// -----------------------------------------------------------------------------
module tb_ccc_pll_sequencer;

  localparam int N_REGS = 2;
  localparam int ARST   = 4;
`ifdef CCC_SEQ_VERIFY_EN
  localparam int CFG_CYC = 4 * N_REGS;
`else
  localparam int CFG_CYC = 2 * N_REGS;
`endif
  // Edges from the START edge to PLL_ARST_N rising.
  localparam int T_WL = 2 * ARST + CFG_CYC;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        START;
  logic [11:0] CFG_ADDR = {6'h05, 6'h02};
  logic [15:0] CFG_DATA = {8'hA5, 8'h3C};
  logic        PRESET_N, PSEL, PENABLE, PWRITE;
  logic [5:0]  PADDR;
  logic [7:0]  PWDATA;
  logic [7:0]  PRDATA;
  logic        PLL_ARST_N, PLL_POWERDOWN_N;
  logic        LOCK;
  logic        BUSY, READY, ERROR, FAB_RESET_N;
  logic        corrupt;

  int vectors     = 0;
  int miscompares = 0;

  // CCC register file model: reads back what was written, optionally
  // corrupted in bit 0.
  assign PRDATA = corrupt ? (PWDATA ^ 8'h01) : PWDATA;

  always #5 CLK = ~CLK;

  ccc_pll_sequencer #(
    .NUM_REGS     (2),
    .ARST_CYCLES  (4),
    .LOCK_STABLE  (8),
    .LOCK_TIMEOUT (100)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .START           (START),
    .CFG_ADDR        (CFG_ADDR),
    .CFG_DATA        (CFG_DATA),
    .PRESET_N        (PRESET_N),
    .PSEL            (PSEL),
    .PENABLE         (PENABLE),
    .PWRITE          (PWRITE),
    .PADDR           (PADDR),
    .PWDATA          (PWDATA),
    .PRDATA          (PRDATA),
    .PLL_ARST_N      (PLL_ARST_N),
    .PLL_POWERDOWN_N (PLL_POWERDOWN_N),
    .LOCK            (LOCK),
    .BUSY            (BUSY),
    .READY           (READY),
    .ERROR           (ERROR),
    .FAB_RESET_N     (FAB_RESET_N)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h, expected %02h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    RESET_N = 1'b0;
    START   = 1'b0;
    LOCK    = 1'b0;
    corrupt = 1'b0;

    // ---- reset state ----
    #2;
    chk1("rst_preset_n", PRESET_N, 1'b0);
    chk1("rst_busy", BUSY, 1'b0);
    chk1("rst_pd_n", PLL_POWERDOWN_N, 1'b0);
    chk1("rst_fab", FAB_RESET_N, 1'b0);
    tick(2);
    RESET_N = 1'b1;
    tick(2);
    chk1("idle_busy", BUSY, 1'b0);
    chk1("idle_psel", PSEL, 1'b0);
    $display("reset: idle checked");

    // ---- nominal ----
    START = 1'b1;
    tick(1);
    START = 1'b0;
    chk1("start_busy", BUSY, 1'b1);
    chk1("pwrdn_preset_n", PRESET_N, 1'b1);
    chk1("pwrdn_pd_n", PLL_POWERDOWN_N, 1'b0);
    chk1("pwrdn_error", ERROR, 1'b0);
`ifndef CCC_SEQ_VERIFY_EN
    tick(3);
    chk1("pwrdn_psel", PSEL, 1'b0);
    tick(1);
    chk1("w0_setup_psel", PSEL, 1'b1);
    chk1("w0_setup_penable", PENABLE, 1'b0);
    chk1("w0_setup_pwrite", PWRITE, 1'b1);
    chk8("w0_paddr", {2'b00, PADDR}, 8'h02);
    chk8("w0_pwdata", PWDATA, 8'h3C);
    tick(1);
    chk1("w0_access_psel", PSEL, 1'b1);
    chk1("w0_access_penable", PENABLE, 1'b1);
    chk8("w0_access_paddr", {2'b00, PADDR}, 8'h02);
    tick(1);
    chk1("w1_setup_penable", PENABLE, 1'b0);
    chk8("w1_paddr", {2'b00, PADDR}, 8'h05);
    chk8("w1_pwdata", PWDATA, 8'hA5);
    tick(1);
    chk1("w1_access_penable", PENABLE, 1'b1);
    tick(1);
    chk1("rel_psel", PSEL, 1'b0);
    chk1("rel_pwrite", PWRITE, 1'b0);
    chk8("rel_paddr_hold", {2'b00, PADDR}, 8'h05);
    chk1("rel_pd_n", PLL_POWERDOWN_N, 1'b1);
    tick(3);
`else
    tick(T_WL - 1);
`endif
    chk1("rel_arst_n_low", PLL_ARST_N, 1'b0);
    chk1("rel_pd_n_high", PLL_POWERDOWN_N, 1'b1);
    tick(1);
    chk1("wl_arst_n", PLL_ARST_N, 1'b1);
    chk1("wl_busy", BUSY, 1'b1);
    tick(10);
    LOCK = 1'b1;
    tick(10);
    chk1("nom_ready_early", READY, 1'b0);
    tick(1);
    chk1("nom_ready", READY, 1'b1);
    chk1("nom_fab", FAB_RESET_N, 1'b1);
    chk1("nom_busy", BUSY, 1'b0);
    $display("nominal: READY at lock+11");

    // ---- lock loss in RUN ----
    LOCK = 1'b0;
    tick(2);
    chk1("loss_ready_hold", READY, 1'b1);
    tick(1);
    chk1("loss_ready", READY, 1'b0);
    chk1("loss_fab", FAB_RESET_N, 1'b0);
    chk1("loss_busy", BUSY, 1'b1);
    chk1("loss_psel", PSEL, 1'b0);
    LOCK = 1'b1;
    tick(10);
    chk1("relock_ready_early", READY, 1'b0);
    chk1("relock_psel", PSEL, 1'b0);
    tick(1);
    chk1("relock_ready", READY, 1'b1);
    chk1("relock_fab", FAB_RESET_N, 1'b1);
    $display("lock loss: READY fell after 3, restored after relock");

    // ---- restart from RUN, then lock glitch ----
    START = 1'b1;
    LOCK  = 1'b0;
    tick(1);
    START = 1'b0;
    chk1("restart_ready", READY, 1'b0);
    chk1("restart_fab", FAB_RESET_N, 1'b0);
    chk1("restart_busy", BUSY, 1'b1);
    tick(T_WL);
    chk1("glitch_arst_n", PLL_ARST_N, 1'b1);
    LOCK = 1'b1;
    tick(5);
    LOCK = 1'b0;
    tick(1);
    LOCK = 1'b1;
    tick(5);
    chk1("glitch_ready_lock11", READY, 1'b0);
    tick(5);
    chk1("glitch_ready_lock16", READY, 1'b0);
    tick(1);
    chk1("glitch_ready_lock17", READY, 1'b1);
    $display("glitch: READY at lock+17");

    // ---- timeout ----
    START = 1'b1;
    LOCK  = 1'b0;
    tick(1);
    START = 1'b0;
    tick(T_WL);
    chk1("tmo_arst_n", PLL_ARST_N, 1'b1);
    tick(99);
    chk1("tmo_error_99", ERROR, 1'b0);
    chk1("tmo_arst_n_99", PLL_ARST_N, 1'b1);
    tick(1);
    chk1("tmo_error", ERROR, 1'b1);
    chk1("tmo_arst_n_low", PLL_ARST_N, 1'b0);
    chk1("tmo_pd_n_low", PLL_POWERDOWN_N, 1'b0);
    chk1("tmo_busy", BUSY, 1'b0);
    chk1("tmo_ready", READY, 1'b0);
    chk1("tmo_preset_n", PRESET_N, 1'b1);
    tick(3);
    chk1("tmo_error_hold", ERROR, 1'b1);
    $display("timeout: ERROR at release+100");

    // ---- retry, then reset mid-transfer ----
    START = 1'b1;
    tick(1);
    START = 1'b0;
    chk1("retry_error", ERROR, 1'b0);
    chk1("retry_busy", BUSY, 1'b1);
    tick(4);
    chk1("retry_psel", PSEL, 1'b1);
    tick(1);
    chk1("retry_penable", PENABLE, 1'b1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk1("arst_penable", PENABLE, 1'b0);
    chk1("arst_psel", PSEL, 1'b0);
    chk1("arst_preset_n", PRESET_N, 1'b0);
    chk1("arst_busy", BUSY, 1'b0);
    chk8("arst_paddr", {2'b00, PADDR}, 8'h00);
    chk8("arst_pwdata", PWDATA, 8'h00);
    tick(2);
    RESET_N = 1'b1;
    tick(3);
    chk1("post_rst_busy", BUSY, 1'b0);
    chk1("post_rst_psel", PSEL, 1'b0);
    START = 1'b1;
    tick(1);
    START = 1'b0;
    chk1("post_rst_start", BUSY, 1'b1);
    $display("reset mid-transfer: outputs cleared, IDLE accepts START");

`ifdef CCC_SEQ_VERIFY_EN
    // ---- read-back mismatch ----
    corrupt = 1'b1;
    tick(4);
    chk1("v_setup_pwrite", PWRITE, 1'b1);
    chk8("v_setup_paddr", {2'b00, PADDR}, 8'h02);
    tick(1);
    chk1("v_access_penable", PENABLE, 1'b1);
    tick(1);
    chk1("v_vsetup_psel", PSEL, 1'b1);
    chk1("v_vsetup_pwrite", PWRITE, 1'b0);
    chk1("v_vsetup_penable", PENABLE, 1'b0);
    chk8("v_vsetup_paddr", {2'b00, PADDR}, 8'h02);
    tick(1);
    chk1("v_vaccess_penable", PENABLE, 1'b1);
    tick(1);
    chk1("v_error", ERROR, 1'b1);
    chk1("v_psel", PSEL, 1'b0);
    chk1("v_busy", BUSY, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk1("v_pd_n_held", PLL_POWERDOWN_N, 1'b0);
    end
    $display("verify: read-back mismatch gives ERROR, PLL kept down");
`else
    tick(4);
    chk1("final_psel", PSEL, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
